// File: rtl/parity_pkg.sv
// Shared types and helpers for the framed parity accumulator.
//   state_e     : frame FSM states (S_IDLE, S_ACCUM, S_HOLD)
//   PAR_EVEN/ODD: values for the ODD parameter of parity_frame_accum
//   PAR_MAX_W   : widest word word_parity() accepts; narrower words are zero-extended,
//                 which leaves the reduction XOR unchanged
//   word_parity : reduction XOR of a word
package parity_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  localparam int unsigned PAR_MAX_W = 256;

  function automatic logic word_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/parity_word.sv
// Combinational parity of a WIDTH-bit word with optional inversion.
//   data_i   [WIDTH-1:0] word to reduce (WIDTH must be <= PAR_MAX_W)
//   parity_o             XOR of all bits of data_i, inverted when INVERT=1
module parity_word
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          INVERT = 1'b0
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  logic [PAR_MAX_W-1:0] data_ext;

  assign data_ext = PAR_MAX_W'(data_i);
  assign parity_o = word_parity(data_ext) ^ INVERT;

endmodule

// File: rtl/parity_frame_accum.sv
// Frame parity accumulator: XOR-accumulates per-beat parity across a frame delimited by
// in_last and presents one result (parity + saturating beat count) the cycle after the
// last beat, behind valid/ready handshakes on both sides.
//   clk, reset             single clock, synchronous active-high reset
//   in_valid/in_ready      input handshake; in_data [WIDTH-1:0], in_last
//   out_valid/out_ready    output handshake; out_parity, out_count [CNT_W-1:0]
// Optional build macro PARITY_FRAME_CHECK_EN adds sideband input in_par and output out_err
// (OR of per-beat sideband parity errors over the frame).
module parity_frame_accum
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter bit          ODD   = PAR_EVEN,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef PARITY_FRAME_CHECK_EN
  input  logic             in_par,
  output logic             out_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count
);

  state_e           state_q;
  logic             acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic             out_parity_q;
  logic [CNT_W-1:0] out_count_q;

  logic             beat_par;
  logic             accept;
  logic             fresh;
  logic             acc_nx;
  logic [CNT_W-1:0] cnt_nx;

  parity_word #(
    .WIDTH  (WIDTH),
    .INVERT (1'b0)
  ) u_beat_par (
    .data_i   (in_data),
    .parity_o (beat_par)
  );

  // Ready whenever the result register is empty or being drained this cycle.
  assign in_ready = !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  // Any beat accepted outside S_ACCUM starts a new frame.
  assign fresh    = (state_q != S_ACCUM);

  always_comb begin
    acc_nx = (fresh ? 1'b0 : acc_q) ^ beat_par;
    cnt_nx = cnt_q;
    if (fresh) begin
      cnt_nx = CNT_W'(1);
    end else if (!(&cnt_q)) begin
      cnt_nx = cnt_q + CNT_W'(1);
    end
  end

`ifdef PARITY_FRAME_CHECK_EN
  logic beat_err;
  logic err_q;
  logic err_nx;
  logic out_err_q;

  // Error when (^in_data ^ in_par) != ODD, i.e. XOR of data and sideband, inverted by ODD.
  parity_word #(
    .WIDTH  (WIDTH + 1),
    .INVERT (ODD)
  ) u_chk_par (
    .data_i   ({in_par, in_data}),
    .parity_o (beat_err)
  );

  assign err_nx  = (fresh ? 1'b0 : err_q) | beat_err;
  assign out_err = out_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q     <= 1'b0;
      out_err_q <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        err_q     <= 1'b0;
        out_err_q <= err_nx;
      end else begin
        err_q <= err_nx;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        state_q     <= S_IDLE;
      end
      // An accept in S_HOLD implies out_ready, so these override the drain above.
      if (accept) begin
        if (in_last) begin
          state_q      <= S_HOLD;
          out_valid_q  <= 1'b1;
          out_parity_q <= acc_nx ^ ODD;
          out_count_q  <= cnt_nx;
          acc_q        <= 1'b0;
          cnt_q        <= '0;
        end else begin
          state_q <= S_ACCUM;
          acc_q   <= acc_nx;
          cnt_q   <= cnt_nx;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_parity = out_parity_q;
  assign out_count  = out_count_q;

endmodule

// File: tb/tb_parity_frame_accum.sv
// Directed bench for parity_frame_accum. Three instances share the input stimulus:
// e_* (ODD=0, CNT_W=8), o_* (ODD=1, CNT_W=8), s_* (ODD=0, CNT_W=2).
module tb_parity_frame_accum;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;
`ifdef PARITY_FRAME_CHECK_EN
  logic       in_par;
  logic       e_out_err, o_out_err, s_out_err;
`endif

  logic       e_in_ready, e_out_valid, e_out_parity;
  logic [7:0] e_out_count;
  logic       o_in_ready, o_out_valid, o_out_parity;
  logic [7:0] o_out_count;
  logic       s_in_ready, s_out_valid, s_out_parity;
  logic [1:0] s_out_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  parity_frame_accum #(.WIDTH(8), .ODD(1'b0), .CNT_W(8)) u_even (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_data(in_data), .in_last(in_last),
`ifdef PARITY_FRAME_CHECK_EN
    .in_par(in_par), .out_err(e_out_err),
`endif
    .out_valid(e_out_valid), .out_ready(out_ready), .out_parity(e_out_parity),
    .out_count(e_out_count)
  );

  parity_frame_accum #(.WIDTH(8), .ODD(1'b1), .CNT_W(8)) u_odd (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_in_ready),
    .in_data(in_data), .in_last(in_last),
`ifdef PARITY_FRAME_CHECK_EN
    .in_par(in_par), .out_err(o_out_err),
`endif
    .out_valid(o_out_valid), .out_ready(out_ready), .out_parity(o_out_parity),
    .out_count(o_out_count)
  );

  parity_frame_accum #(.WIDTH(8), .ODD(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_last(in_last),
`ifdef PARITY_FRAME_CHECK_EN
    .in_par(in_par), .out_err(s_out_err),
`endif
    .out_valid(s_out_valid), .out_ready(out_ready), .out_parity(s_out_parity),
    .out_count(s_out_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one cycle; callers ensure in_ready is high.
  task automatic beat(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
`ifdef PARITY_FRAME_CHECK_EN
    in_par   = ^d;
`endif
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++; if (e_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", e_out_valid); end
    n_tests++; if (e_out_parity !== 1'b0) begin n_fail++; $display("FAIL rst_parity got %b exp 0", e_out_parity); end
    n_tests++; if (e_out_count !== 8'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", e_out_count); end
    n_tests++; if (e_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", e_in_ready); end
  endtask

  task automatic test_two_beat();
    out_ready = 1'b1;
    beat(8'h01, 1'b0);
    n_tests++; if (e_out_valid !== 1'b0) begin n_fail++; $display("FAIL tb_mid_valid got %b exp 0", e_out_valid); end
    beat(8'h03, 1'b1);
    n_tests++; if (e_out_valid !== 1'b1) begin n_fail++; $display("FAIL tb_valid got %b exp 1", e_out_valid); end
    n_tests++; if (e_out_parity !== 1'b1) begin n_fail++; $display("FAIL tb_parity got %b exp 1", e_out_parity); end
    n_tests++; if (e_out_count !== 8'd2) begin n_fail++; $display("FAIL tb_count got %0d exp 2", e_out_count); end
    n_tests++; if (o_out_parity !== 1'b0) begin n_fail++; $display("FAIL tb_odd_parity got %b exp 0", o_out_parity); end
    step();
    n_tests++; if (e_out_valid !== 1'b0) begin n_fail++; $display("FAIL tb_drained got %b exp 0", e_out_valid); end
  endtask

  task automatic test_single_beat_odd();
    beat(8'hFF, 1'b1);
    n_tests++; if (o_out_valid !== 1'b1) begin n_fail++; $display("FAIL sb_valid got %b exp 1", o_out_valid); end
    n_tests++; if (o_out_parity !== 1'b1) begin n_fail++; $display("FAIL sb_odd_parity got %b exp 1", o_out_parity); end
    n_tests++; if (o_out_count !== 8'd1) begin n_fail++; $display("FAIL sb_count got %0d exp 1", o_out_count); end
    n_tests++; if (e_out_parity !== 1'b0) begin n_fail++; $display("FAIL sb_even_parity got %b exp 0", e_out_parity); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(8'h03, 1'b1);
    n_tests++; if (e_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b exp 1", e_out_valid); end
    // New beat pending while the result is stalled.
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
`ifdef PARITY_FRAME_CHECK_EN
    in_par = 1'b1;
`endif
    #1;
    n_tests++; if (e_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", e_in_ready); end
    step();
    n_tests++; if (e_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid got %b exp 1", e_out_valid); end
    n_tests++; if (e_out_parity !== 1'b0) begin n_fail++; $display("FAIL bp_hold_parity got %b exp 0", e_out_parity); end
    n_tests++; if (e_out_count !== 8'd1) begin n_fail++; $display("FAIL bp_hold_count got %0d exp 1", e_out_count); end
    out_ready = 1'b1;
    #1;
    n_tests++; if (e_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain_ready got %b exp 1", e_in_ready); end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    // Drain and accept in one cycle: new single-beat result replaces the old one.
    n_tests++; if (e_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_new_valid got %b exp 1", e_out_valid); end
    n_tests++; if (e_out_parity !== 1'b1) begin n_fail++; $display("FAIL bp_new_parity got %b exp 1", e_out_parity); end
    step();
    n_tests++; if (e_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid got %b exp 0", e_out_valid); end
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h04, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++; if (e_in_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_ready got %b exp 1", e_in_ready); end
    beat(8'h80, 1'b1);
    n_tests++; if (e_out_parity !== 1'b1) begin n_fail++; $display("FAIL rmf_parity got %b exp 1", e_out_parity); end
    n_tests++; if (e_out_count !== 8'd1) begin n_fail++; $display("FAIL rmf_count got %0d exp 1", e_out_count); end
    step();
    // Reset during a stalled result.
    out_ready = 1'b0;
    beat(8'h01, 1'b1);
    n_tests++; if (e_in_ready !== 1'b0) begin n_fail++; $display("FAIL rmh_stall got %b exp 0", e_in_ready); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++; if (e_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmh_valid got %b exp 0", e_out_valid); end
    n_tests++; if (e_in_ready !== 1'b1) begin n_fail++; $display("FAIL rmh_ready got %b exp 1", e_in_ready); end
    n_tests++; if (e_out_count !== 8'd0) begin n_fail++; $display("FAIL rmh_count got %0d exp 0", e_out_count); end
    out_ready = 1'b1;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) beat(8'h00, (i == 4));
    n_tests++; if (s_out_count !== 2'd3) begin n_fail++; $display("FAIL sat_count got %0d exp 3", s_out_count); end
    n_tests++; if (s_out_parity !== 1'b0) begin n_fail++; $display("FAIL sat_parity got %b exp 0", s_out_parity); end
    n_tests++; if (e_out_count !== 8'd5) begin n_fail++; $display("FAIL sat_wide_count got %0d exp 5", e_out_count); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    beat(8'h01, 1'b1);
    n_tests++; if (e_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_a_valid got %b exp 1", e_out_valid); end
    n_tests++; if (e_out_parity !== 1'b1) begin n_fail++; $display("FAIL b2b_a_parity got %b exp 1", e_out_parity); end
    beat(8'h01, 1'b0);
    n_tests++; if (e_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid got %b exp 0", e_out_valid); end
    beat(8'h01, 1'b1);
    n_tests++; if (e_out_parity !== 1'b0) begin n_fail++; $display("FAIL b2b_b_parity got %b exp 0", e_out_parity); end
    n_tests++; if (e_out_count !== 8'd2) begin n_fail++; $display("FAIL b2b_b_count got %0d exp 2", e_out_count); end
    step();
  endtask

`ifdef PARITY_FRAME_CHECK_EN
  task automatic test_check();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h01; in_par = 1'b1; in_last = 1'b0;
    step();
    in_data = 8'h02; in_par = 1'b0; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_tests++; if (e_out_err !== 1'b1) begin n_fail++; $display("FAIL chk_err got %b exp 1", e_out_err); end
    beat(8'h03, 1'b0);
    beat(8'h07, 1'b1);
    n_tests++; if (e_out_err !== 1'b0) begin n_fail++; $display("FAIL chk_clean got %b exp 0", e_out_err); end
    step();
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
`ifdef PARITY_FRAME_CHECK_EN
    in_par = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_two_beat();
    test_single_beat_odd();
    test_backpressure();
    test_reset_mid_frame();
    test_saturation();
    test_back_to_back();
`ifdef PARITY_FRAME_CHECK_EN
    test_check();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
